// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock time-setting controller.
// Holds the setting FSM states, the field-select encodings and the BCD limits.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HR   = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;

   localparam logic [3:0] HR_MAX_T       = 4'd2;
   localparam logic [3:0] HR_MAX_U_AT_T2 = 4'd3;
   localparam logic [3:0] MIN_MAX_T      = 4'd5;
   localparam logic [3:0] DIGIT_MAX      = 4'd9;

   function automatic logic [1:0] field_of(input state_t s);
      case (s)
         SET_HR:  return FIELD_HR;
         SET_MIN: return FIELD_MIN;
         default: return FIELD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/time_set_ctrl_edge_det.sv
// Rising-edge detector for an already synchronized, debounced button level.
// rise is combinational from level and the registered previous level.
module edge_det (
   input  logic clk,
   input  logic resetn,
   input  logic level,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) prev_q <= 1'b0;
      else         prev_q <= level;
   end

   // prev cleared in reset, so a button held through release counts as a press
   assign rise = level & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/up button driven time-setting FSM producing BCD load strobes for hours and minutes.
// All outputs registered: one-cycle strobes appear the cycle after the clk edge that sees the press.
module time_set_ctrl
   import alarm_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       mode_btn,
   input  logic       up_btn,
   input  logic [3:0] hr_T_q,
   input  logic [3:0] hr_U_q,
   input  logic [3:0] min_T_q,
   input  logic [3:0] min_U_q,
   output logic       set_hr_T,
   output logic       set_hr_U,
   output logic       set_min_T,
   output logic       set_min_U,
   output logic [3:0] new_hr_T,
   output logic [3:0] new_hr_U,
   output logic [3:0] new_min_T,
   output logic [3:0] new_min_U,
   output logic       clr_sec,
   output logic [1:0] field
);

   logic mode_rise, up_rise;

   edge_det u_mode_edge (.clk(clk), .resetn(resetn), .level(mode_btn), .rise(mode_rise));
   edge_det u_up_edge   (.clk(clk), .resetn(resetn), .level(up_btn),   .rise(up_rise));

   state_t     state_q, state_d;
   logic [1:0] field_q;
   logic       set_hr_q, set_hr_d, set_min_q, set_min_d, clr_sec_q, clr_sec_d;
   logic [3:0] nhr_T_q, nhr_T_d, nhr_U_q, nhr_U_d;
   logic [3:0] nmin_T_q, nmin_T_d, nmin_U_q, nmin_U_d;
   logic [3:0] hr_inc_T, hr_inc_U, min_inc_T, min_inc_U;

   // Increment with wrap; any out-of-range hour (including 23) lands on 00
   always_comb begin
      hr_inc_T = 4'd0;
      hr_inc_U = 4'd0;
      if (hr_T_q > HR_MAX_T || hr_U_q > DIGIT_MAX ||
          (hr_T_q == HR_MAX_T && hr_U_q >= HR_MAX_U_AT_T2)) begin
         hr_inc_T = 4'd0;
         hr_inc_U = 4'd0;
      end else if (hr_U_q == DIGIT_MAX) begin
         hr_inc_T = hr_T_q + 4'd1;
         hr_inc_U = 4'd0;
      end else begin
         hr_inc_T = hr_T_q;
         hr_inc_U = hr_U_q + 4'd1;
      end
   end

   always_comb begin
      min_inc_T = 4'd0;
      min_inc_U = 4'd0;
      if (min_T_q > MIN_MAX_T || min_U_q > DIGIT_MAX ||
          (min_T_q == MIN_MAX_T && min_U_q == DIGIT_MAX)) begin
         min_inc_T = 4'd0;
         min_inc_U = 4'd0;
      end else if (min_U_q == DIGIT_MAX) begin
         min_inc_T = min_T_q + 4'd1;
         min_inc_U = 4'd0;
      end else begin
         min_inc_T = min_T_q;
         min_inc_U = min_U_q + 4'd1;
      end
   end

   // Mode press takes priority; a simultaneous up press is dropped
   always_comb begin
      state_d   = state_q;
      set_hr_d  = 1'b0;
      set_min_d = 1'b0;
      clr_sec_d = 1'b0;
      nhr_T_d   = 4'd0;
      nhr_U_d   = 4'd0;
      nmin_T_d  = 4'd0;
      nmin_U_d  = 4'd0;
      case (state_q)
         IDLE: begin
            if (mode_rise) state_d = SET_HR;
         end
         SET_HR: begin
            if (mode_rise) begin
               state_d = SET_MIN;
            end else if (up_rise) begin
               set_hr_d = 1'b1;
               nhr_T_d  = hr_inc_T;
               nhr_U_d  = hr_inc_U;
            end
         end
         SET_MIN: begin
            if (mode_rise) begin
               state_d   = IDLE;
               clr_sec_d = 1'b1;
            end else if (up_rise) begin
               set_min_d = 1'b1;
               nmin_T_d  = min_inc_T;
               nmin_U_d  = min_inc_U;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         field_q   <= FIELD_NONE;
         set_hr_q  <= 1'b0;
         set_min_q <= 1'b0;
         clr_sec_q <= 1'b0;
         nhr_T_q   <= 4'd0;
         nhr_U_q   <= 4'd0;
         nmin_T_q  <= 4'd0;
         nmin_U_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_of(state_d);
         set_hr_q  <= set_hr_d;
         set_min_q <= set_min_d;
         clr_sec_q <= clr_sec_d;
         nhr_T_q   <= nhr_T_d;
         nhr_U_q   <= nhr_U_d;
         nmin_T_q  <= nmin_T_d;
         nmin_U_q  <= nmin_U_d;
      end
   end

   assign set_hr_T  = set_hr_q;
   assign set_hr_U  = set_hr_q;
   assign set_min_T = set_min_q;
   assign set_min_U = set_min_q;
   assign new_hr_T  = nhr_T_q;
   assign new_hr_U  = nhr_U_q;
   assign new_min_T = nmin_T_q;
   assign new_min_U = nmin_U_q;
   assign clr_sec   = clr_sec_q;
   assign field     = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a time-of-day reference model.
// Directed scenarios first, then random button/digit traffic with occasional async resets.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       mode_btn, up_btn;
   logic [3:0] hr_T_q, hr_U_q, min_T_q, min_U_q;
   logic       set_hr_T, set_hr_U, set_min_T, set_min_U, clr_sec;
   logic [3:0] new_hr_T, new_hr_U, new_min_T, new_min_U;
   logic [1:0] field;

   time_set_ctrl dut (
      .clk(clk), .resetn(resetn), .mode_btn(mode_btn), .up_btn(up_btn),
      .hr_T_q(hr_T_q), .hr_U_q(hr_U_q), .min_T_q(min_T_q), .min_U_q(min_U_q),
      .set_hr_T(set_hr_T), .set_hr_U(set_hr_U), .set_min_T(set_min_T), .set_min_U(set_min_U),
      .new_hr_T(new_hr_T), .new_hr_U(new_hr_U), .new_min_T(new_min_T), .new_min_U(new_min_U),
      .clr_sec(clr_sec), .field(field)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: setting step (0 none, 1 hours, 2 minutes), last button levels,
   // and the expected registered outputs as whole hour/minute numbers (-1 = no load).
   int m_step, m_pm, m_pu;
   int e_hr, e_min, e_clr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int next_hour(input int t, input int u);
      if (t > 9 || u > 9 || t * 10 + u > 23) return 0;
      return (t * 10 + u + 1) % 24;
   endfunction

   function automatic int next_minute(input int t, input int u);
      if (t > 5 || u > 9) return 0;
      return (t * 10 + u + 1) % 60;
   endfunction

   function automatic logic [31:0] dut_word();
      return {9'd0, field, set_hr_T, set_hr_U, set_min_T, set_min_U,
              new_hr_T, new_hr_U, new_min_T, new_min_U, clr_sec};
   endfunction

   function automatic logic [31:0] exp_word();
      logic [31:0] w;
      logic [3:0]  ht, hu, mt, mu;
      ht = (e_hr  >= 0) ? 4'(e_hr / 10)  : 4'd0;
      hu = (e_hr  >= 0) ? 4'(e_hr % 10)  : 4'd0;
      mt = (e_min >= 0) ? 4'(e_min / 10) : 4'd0;
      mu = (e_min >= 0) ? 4'(e_min % 10) : 4'd0;
      w = {9'd0, 2'(m_step), e_hr >= 0, e_hr >= 0, e_min >= 0, e_min >= 0,
           ht, hu, mt, mu, e_clr != 0};
      return w;
   endfunction

   task automatic model_reset();
      m_step = 0; m_pm = 0; m_pu = 0;
      e_hr = -1; e_min = -1; e_clr = 0;
   endtask

   task automatic model_clock();
      int me, ue;
      me = (mode_btn && m_pm == 0) ? 1 : 0;
      ue = (up_btn && m_pu == 0) ? 1 : 0;
      m_pm = int'(mode_btn);
      m_pu = int'(up_btn);
      e_hr = -1; e_min = -1; e_clr = 0;
      if (me != 0) begin
         if (m_step == 2) e_clr = 1;
         m_step = (m_step + 1) % 3;
      end else if (ue != 0) begin
         if (m_step == 1) e_hr  = next_hour(int'(hr_T_q), int'(hr_U_q));
         if (m_step == 2) e_min = next_minute(int'(min_T_q), int'(min_U_q));
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge
   task automatic cyc();
      @(posedge clk);
      if (resetn) model_clock();
      @(negedge clk);
      chk("outs", dut_word(), exp_word());
   endtask

   task automatic mid_reset();
      #2 resetn = 1'b0;
      model_reset();
      #1 chk("rst_outs", dut_word(), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic set_digits(input int ht, input int hu, input int mt, input int mu);
      hr_T_q = 4'(ht); hr_U_q = 4'(hu); min_T_q = 4'(mt); min_U_q = 4'(mu);
   endtask

   initial begin
      int strobes;
      resetn = 1'b0; mode_btn = 1'b0; up_btn = 1'b0;
      set_digits(0, 0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset", dut_word(), 32'd0);
      resetn = 1'b1;
      cyc();

      // 19 -> 20 in hour setting
      set_digits(1, 9, 3, 4);
      mode_btn = 1'b1; cyc(); mode_btn = 1'b0; cyc();
      chk("r28_field", 32'(field), 32'd1);
      up_btn = 1'b1; cyc();
      chk("r28_hr", {24'd0, new_hr_T, new_hr_U}, 32'h20);
      chk("r28_stb", {30'd0, set_hr_T, set_hr_U}, 32'd3);
      up_btn = 1'b0; cyc();
      chk("r28_width", {30'd0, set_hr_T, set_hr_U}, 32'd0);

      // 23 wraps to 00
      set_digits(2, 3, 3, 4);
      up_btn = 1'b1; cyc(); up_btn = 1'b0; cyc();

      // 59 wraps to 00 with no hour load, then leave and clear seconds
      mode_btn = 1'b1; cyc(); mode_btn = 1'b0; cyc();
      set_digits(1, 1, 5, 9);
      up_btn = 1'b1; cyc(); up_btn = 1'b0; cyc();
      mode_btn = 1'b1; cyc();
      chk("r30_clr", {30'd0, field, clr_sec}, 32'd1);
      mode_btn = 1'b0; cyc();

      // Mode and up together in hour setting
      mode_btn = 1'b1; cyc(); mode_btn = 1'b0; cyc();
      mode_btn = 1'b1; up_btn = 1'b1; cyc();
      chk("r31_field", 32'(field), 32'd2);
      mode_btn = 1'b0; up_btn = 1'b0; cyc();

      // Held up button in minute setting: one load of 08
      set_digits(1, 2, 0, 7);
      strobes = 0;
      up_btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (set_min_U) strobes++;
      end
      chk("r32_count", 32'(strobes), 32'd1);
      up_btn = 1'b0; cyc();

      // Reset on the cycle of an up press in minute setting
      up_btn = 1'b1;
      mid_reset();
      cyc();
      up_btn = 1'b0; cyc();

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
         if ($urandom_range(0, 2) == 0) up_btn = ~up_btn;
         hr_T_q  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         hr_U_q  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         min_T_q = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
         min_U_q = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         if ($urandom_range(0, 299) == 0) mid_reset();
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
